// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - request/response bundle of the universal shift register
//
// master : drives load, d, start, mode, shamt, ser_in; observes q, busy, done, ser_out
// slave  : the register itself (mirror of master)
// parity : present only when USR_PARITY_EN is defined
interface univ_shift_reg_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic               load;
    logic [WIDTH-1:0]   d;
    logic               start;
    logic [1:0]         mode;
    logic [SHAMT_W-1:0] shamt;
    logic               ser_in;
    logic [WIDTH-1:0]   q;
    logic               busy;
    logic               done;
    logic               ser_out;
`ifdef USR_PARITY_EN
    logic               parity;
`endif

    modport master (
        output load, d, start, mode, shamt, ser_in,
`ifdef USR_PARITY_EN
        input  parity,
`endif
        input  q, busy, done, ser_out
    );

    modport slave (
        input  load, d, start, mode, shamt, ser_in,
`ifdef USR_PARITY_EN
        output parity,
`endif
        output q, busy, done, ser_out
    );
endinterface

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal register: parallel load, multi-cycle shift/rotate
//
// Ports
//   clk    : clock, every register updates on the falling edge
//   reset  : synchronous active-high reset, sampled on the falling edge
//   bus    : univ_shift_reg_if.slave
//            load/d       parallel load (idle only, wins over start)
//            start/mode/shamt  shift request (idle only); mode 00 SHL, 01 SHR, 10 ROL, 11 ROR
//            ser_in       fill bit for SHL/SHR, sampled live on each step
//            q            register contents
//            busy         high while stepping
//            done         one-cycle completion pulse
//            ser_out      bit pushed out on the most recent step
//            parity       even parity of q (USR_PARITY_EN only)
// Parameters
//   WIDTH   register width, >= 2
//   SHAMT_W shift-amount width, 2**SHAMT_W >= WIDTH
// Configuration macro
//   USR_PARITY_EN  adds the registered parity output
module univ_shift_reg #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    univ_shift_reg_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [SHAMT_W-1:0] COUNT_LAST = SHAMT_W'(1);

    logic [0:0]         state,  state_nxt;
    logic [SHAMT_W-1:0] count,  count_nxt;
    logic [1:0]         mode_r, mode_nxt;
    logic [WIDTH-1:0]   q_r,    q_nxt;
    logic               busy_r, busy_nxt;
    logic               done_r, done_nxt;
    logic               sout_r, sout_nxt;

    // Result of one single-bit step in the latched mode. Uses mode_r, not the
    // live port, so mode changes during an operation have no effect.
    logic [WIDTH-1:0]   step_q;
    logic               step_out;

    always_comb begin
        step_q   = q_r;
        step_out = sout_r;
        case (mode_r)
            MODE_SHL: begin
                step_q   = {q_r[WIDTH-2:0], bus.ser_in};
                step_out = q_r[WIDTH-1];
            end
            MODE_SHR: begin
                step_q   = {bus.ser_in, q_r[WIDTH-1:1]};
                step_out = q_r[0];
            end
            MODE_ROL: begin
                step_q   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                step_out = q_r[WIDTH-1];
            end
            MODE_ROR: begin
                step_q   = {q_r[0], q_r[WIDTH-1:1]};
                step_out = q_r[0];
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        mode_nxt  = mode_r;
        q_nxt     = q_r;
        busy_nxt  = busy_r;
        sout_nxt  = sout_r;
        done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.load) begin
                    q_nxt = bus.d;
                end else if (bus.start) begin
                    if (bus.shamt == '0) begin
                        // Zero-length request completes immediately.
                        done_nxt = 1'b1;
                    end else begin
                        // Acceptance edge only latches the request; the first
                        // step happens on the following edge.
                        mode_nxt  = bus.mode;
                        count_nxt = bus.shamt;
                        busy_nxt  = 1'b1;
                        state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                q_nxt     = step_q;
                sout_nxt  = step_out;
                count_nxt = count - 1'b1;
                if (count == COUNT_LAST) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            mode_r <= MODE_SHL;
            q_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sout_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            mode_r <= mode_nxt;
            q_r    <= q_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
            sout_r <= sout_nxt;
        end
    end

    assign bus.q       = q_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.ser_out = sout_r;

`ifdef USR_PARITY_EN
    // Computed from q_nxt so it lands on the same edge as q and never lags it.
    logic parity_r;

    always_ff @(negedge clk) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= ^q_nxt;
        end
    end

    assign bus.parity = parity_r;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

    localparam int W    = 8;
    localparam int SW   = 3;
    localparam int MASK = (1 << W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    univ_shift_reg_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

    univ_shift_reg #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register value, steps still owed, latched mode.
    int mq    = 0;
    int mrem  = 0;
    int mmode = 0;
    int mdone = 0;
    int msout = 0;

    always @(negedge clk) begin : ref_model
        int si;
        si = int'(bus.ser_in);
        if (reset) begin
            mq = 0; mrem = 0; mdone = 0; msout = 0;
        end else begin
            mdone = 0;
            if (mrem == 0) begin
                if (bus.load) begin
                    mq = int'(bus.d);
                end else if (bus.start) begin
                    if (bus.shamt == 0) begin
                        mdone = 1;
                    end else begin
                        mrem  = int'(bus.shamt);
                        mmode = int'(bus.mode);
                    end
                end
            end else begin
                case (mmode)
                    0: begin msout = (mq >> (W - 1)) & 1; mq = ((mq * 2) + si) & MASK; end
                    1: begin msout = mq & 1; mq = (mq / 2) + si * (1 << (W - 1)); end
                    2: begin msout = (mq >> (W - 1)) & 1; mq = ((mq * 2) + msout) & MASK; end
                    default: begin msout = mq & 1; mq = (mq / 2) + msout * (1 << (W - 1)); end
                endcase
                mrem = mrem - 1;
                if (mrem == 0) mdone = 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},    32'(bus.q),       32'(mq));
        check({tag, ".busy"}, 32'(bus.busy),    32'(mrem != 0));
        check({tag, ".done"}, 32'(bus.done),    32'(mdone));
        check({tag, ".sout"}, 32'(bus.ser_out), 32'(msout));
`ifdef USR_PARITY_EN
        check({tag, ".par"},  32'(bus.parity),  32'($countones(mq) & 1));
`endif
    endtask

    task automatic drive(input logic l, input logic [W-1:0] dd, input logic s,
                         input logic [1:0] m, input logic [SW-1:0] sh, input logic si);
        bus.load   = l;
        bus.d      = dd;
        bus.start  = s;
        bus.mode   = m;
        bus.shamt  = sh;
        bus.ser_in = si;
    endtask

    task automatic rand_drive();
        bus.load   = ($urandom_range(0, 3) == 0);
        bus.d      = W'($urandom);
        bus.start  = ($urandom_range(0, 2) == 0);
        bus.mode   = 2'($urandom);
        bus.shamt  = SW'($urandom);
        bus.ser_in = 1'($urandom);
    endtask

    // Inputs change after posedge; DUT and model update on negedge; compare on posedge.
    task automatic cyc(input string tag);
        @(negedge clk);
        @(posedge clk);
        check_all(tag);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 2'b00, '0, 1'b0);
        reset = 1'b1;
        cyc("rst0");
        cyc("rst1");
        check("rst_q", 32'(bus.q), 32'd0);
        reset = 1'b0;

        // Reset held two edges in the middle of random traffic
        repeat (10) begin rand_drive(); cyc("pre"); end
        reset = 1'b1;
        rand_drive(); cyc("t1a");
        rand_drive(); cyc("t1b");
        check("t1_q",    32'(bus.q),       32'd0);
        check("t1_busy", 32'(bus.busy),    32'd0);
        check("t1_done", 32'(bus.done),    32'd0);
        check("t1_sout", 32'(bus.ser_out), 32'd0);
        reset = 1'b0;

        // Load wins over start
        drive(1'b1, 8'hA5, 1'b1, 2'b00, 3'd3, 1'b0); cyc("t2");
        check("t2_q",    32'(bus.q),    32'hA5);
        check("t2_busy", 32'(bus.busy), 32'd0);
        check("t2_done", 32'(bus.done), 32'd0);
        drive(1'b0, '0, 1'b0, 2'b00, '0, 1'b0); cyc("t2h");
        check("t2h_busy", 32'(bus.busy), 32'd0);

        // ROL 81 by 3, with load/start/mode noise during the shift
        drive(1'b1, 8'h81, 1'b0, 2'b00, '0, 1'b0); cyc("t3ld");
        drive(1'b0, '0, 1'b1, 2'b10, 3'd3, 1'b0); cyc("t3acc");
        check("t3acc_busy", 32'(bus.busy), 32'd1);
        check("t3acc_q",    32'(bus.q),    32'h81);
        drive(1'b1, 8'hFF, 1'b1, 2'b01, 3'd1, 1'b1); cyc("t3e1");
        check("t3e1_q", 32'(bus.q), 32'h03);
        drive(1'b0, '0, 1'b0, 2'b00, '0, 1'b0); cyc("t3e2");
        check("t3e2_q", 32'(bus.q), 32'h06);
        cyc("t3e3");
        check("t3e3_q",    32'(bus.q),       32'h0C);
        check("t3e3_done", 32'(bus.done),    32'd1);
        check("t3e3_busy", 32'(bus.busy),    32'd0);
        check("t3e3_sout", 32'(bus.ser_out), 32'd0);
        cyc("t3post");
        check("t3post_done", 32'(bus.done), 32'd0);

        // SHR 0F by 4 with zero fill
        drive(1'b1, 8'h0F, 1'b0, 2'b00, '0, 1'b0); cyc("t4ld");
        drive(1'b0, '0, 1'b1, 2'b01, 3'd4, 1'b0); cyc("t4acc");
        drive(1'b0, '0, 1'b0, 2'b00, '0, 1'b0);
        repeat (4) cyc("t4s");
        check("t4_q",    32'(bus.q),       32'h00);
        check("t4_sout", 32'(bus.ser_out), 32'd1);
        check("t4_done", 32'(bus.done),    32'd1);

        // SHL FF by 7, load ignored while busy, reset at step 3
        drive(1'b1, 8'hFF, 1'b0, 2'b00, '0, 1'b0); cyc("t5ld");
        drive(1'b0, '0, 1'b1, 2'b00, 3'd7, 1'b1); cyc("t5acc");
        drive(1'b1, 8'h33, 1'b0, 2'b00, '0, 1'b1); cyc("t5e1");
        check("t5e1_q", 32'(bus.q), 32'hFF);
        drive(1'b0, '0, 1'b0, 2'b00, '0, 1'b0); cyc("t5e2");
        check("t5e2_q", 32'(bus.q), 32'hFE);
        reset = 1'b1; cyc("t5rst");
        reset = 1'b0;
        check("t5_q",    32'(bus.q),    32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        repeat (8) begin
            cyc("t5after");
            check("t5_nodone", 32'(bus.done), 32'd0);
        end

        // Zero-length request
        drive(1'b1, 8'hA5, 1'b0, 2'b00, '0, 1'b0); cyc("t6ld");
        drive(1'b0, '0, 1'b1, 2'b11, 3'd0, 1'b0); cyc("t6acc");
        check("t6_done", 32'(bus.done), 32'd1);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_q",    32'(bus.q),    32'hA5);
`ifdef USR_PARITY_EN
        check("t6_par",  32'(bus.parity), 32'd0);
`endif
        drive(1'b0, '0, 1'b0, 2'b00, '0, 1'b0); cyc("t6post");
        check("t6post_done", 32'(bus.done), 32'd0);

        // Back-to-back: start held high, re-accepted on the edge after done
        drive(1'b0, '0, 1'b1, 2'b11, 3'd2, 1'b0);
        repeat (9) cyc("b2b");

        // Long SHR by 7 with ones fill
        drive(1'b0, '0, 1'b1, 2'b01, 3'd7, 1'b1); cyc("fillacc");
        drive(1'b0, '0, 1'b0, 2'b00, '0, 1'b1);
        repeat (8) cyc("fill");

        // Random traffic
        repeat (600) begin
            reset = ($urandom_range(0, 39) == 0);
            rand_drive();
            cyc("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
